// File: rtl/r_resp_memory_if.sv
// Store and release handshake bundle between the ordering unit and the R-channel response memory.
interface r_resp_memory_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RESP_WIDTH = 2
);
    logic                  store_valid;
    logic                  store_ready;
    logic [ID_WIDTH-1:0]   store_id;
    logic [DATA_WIDTH-1:0] store_data;
    logic [RESP_WIDTH-1:0] store_resp;
    logic                  store_last;

    logic [ID_WIDTH-1:0]   rel_uid;
    logic                  rel_ready;
    logic                  rel_valid;
    logic [DATA_WIDTH-1:0] rel_data;
    logic [RESP_WIDTH-1:0] rel_resp;
    logic                  rel_last;

    modport master (
        output store_valid, store_id, store_data, store_resp, store_last, rel_uid, rel_ready,
        input  store_ready, rel_valid, rel_data, rel_resp, rel_last
    );

    modport slave (
        input  store_valid, store_id, store_data, store_resp, store_last, rel_uid, rel_ready,
        output store_ready, rel_valid, rel_data, rel_resp, rel_last
    );
endinterface

// File: rtl/r_resp_memory.sv
// Response memory for R-channel reordering: shared slot pool, one linked FIFO per uid.
// Optional protocol checker enabled by defining R_RESP_MEM_ERR_EN.
module r_resp_memory #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_LEN    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    r_resp_memory_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned NUM_UID = 2 ** ID_WIDTH;

    typedef struct packed {
        logic                  last;
        logic [RESP_WIDTH-1:0] resp;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t            r_mem      [DEPTH];
    logic [PTR_W-1:0] r_next_ptr [DEPTH];
    logic [DEPTH-1:0] r_free_map;
    logic [PTR_W-1:0] r_head     [NUM_UID];
    logic [PTR_W-1:0] r_tail     [NUM_UID];
    logic [CNT_W-1:0] r_cnt      [NUM_UID];
    logic [OCC_W-1:0] r_occupancy;

    logic [PTR_W-1:0] w_alloc_slot;
    logic [DEPTH-1:0] w_alloc_mask;
    logic [DEPTH-1:0] w_rel_mask;
    logic [PTR_W-1:0] w_rel_head;
    beat_t            w_rel_beat;
    logic             w_store_fire;
    logic             w_rel_fire;
    logic             w_same_uid;
    logic             w_store_cnt_zero;
    logic             w_rel_cnt_one;

    // Lowest-index free slot from the registered map; slots freed this cycle wait a cycle.
    always_comb begin
        w_alloc_slot = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (r_free_map[i]) w_alloc_slot = PTR_W'(i);
        end
    end

    assign bus.store_ready = (r_occupancy != OCC_W'(DEPTH)) &&
                             (r_cnt[bus.store_id] != CNT_W'(MAX_LEN));
    assign w_store_fire    = bus.store_valid && bus.store_ready;

    assign w_rel_head      = r_head[bus.rel_uid];
    assign w_rel_beat      = r_mem[w_rel_head];
    assign bus.rel_valid   = (r_cnt[bus.rel_uid] != '0);
    assign bus.rel_data    = w_rel_beat.data;
    assign bus.rel_resp    = w_rel_beat.resp;
    assign bus.rel_last    = w_rel_beat.last;
    assign w_rel_fire      = bus.rel_valid && bus.rel_ready;

    assign w_same_uid       = (bus.store_id == bus.rel_uid);
    assign w_store_cnt_zero = (r_cnt[bus.store_id] == '0);
    assign w_rel_cnt_one    = (r_cnt[bus.rel_uid] == CNT_W'(1));
    assign w_alloc_mask     = w_store_fire ? (DEPTH'(1) << w_alloc_slot) : '0;
    assign w_rel_mask       = w_rel_fire   ? (DEPTH'(1) << w_rel_head)   : '0;

    // Payload and link storage carry no reset; validity lives in free_map and cnt.
    always_ff @(posedge clk) begin
        if (w_store_fire) begin
            r_mem[w_alloc_slot] <= '{last: bus.store_last, resp: bus.store_resp, data: bus.store_data};
            if (!w_store_cnt_zero) r_next_ptr[r_tail[bus.store_id]] <= w_alloc_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_map  <= '1;
            r_occupancy <= '0;
            for (int u = 0; u < int'(NUM_UID); u++) begin
                r_head[u] <= '0;
                r_tail[u] <= '0;
                r_cnt[u]  <= '0;
            end
        end else begin
            r_free_map <= (r_free_map & ~w_alloc_mask) | w_rel_mask;

            if (w_store_fire && !w_rel_fire)      r_occupancy <= r_occupancy + OCC_W'(1);
            else if (w_rel_fire && !w_store_fire) r_occupancy <= r_occupancy - OCC_W'(1);

            if (w_store_fire) begin
                r_tail[bus.store_id] <= w_alloc_slot;
                if (w_store_cnt_zero) r_head[bus.store_id] <= w_alloc_slot;
                if (!(w_rel_fire && w_same_uid))
                    r_cnt[bus.store_id] <= r_cnt[bus.store_id] + CNT_W'(1);
            end

            // A single-beat uid refilled in the same cycle hands its head straight to the new slot.
            if (w_rel_fire) begin
                if (w_store_fire && w_same_uid && w_rel_cnt_one)
                    r_head[bus.rel_uid] <= w_alloc_slot;
                else
                    r_head[bus.rel_uid] <= r_next_ptr[w_rel_head];
                if (!(w_store_fire && w_same_uid))
                    r_cnt[bus.rel_uid] <= r_cnt[bus.rel_uid] - CNT_W'(1);
            end
        end
    end

    assign occupancy = r_occupancy;

`ifdef R_RESP_MEM_ERR_EN
    logic [CNT_W-1:0] r_nlast [NUM_UID];
    logic             r_err;
    logic             w_err_limit;
    logic             w_err_last;
    logic             w_store_is_last;
    logic             w_rel_is_last;

    assign w_store_is_last = w_store_fire && bus.store_last;
    assign w_rel_is_last   = w_rel_fire && w_rel_beat.last;
    assign w_err_limit     = bus.store_valid && !bus.store_ready &&
                             (r_cnt[bus.store_id] == CNT_W'(MAX_LEN));
    // Last beat leaving with more beats behind it while this uid holds at most one burst end.
    assign w_err_last      = w_rel_is_last && (r_cnt[bus.rel_uid] > CNT_W'(1)) &&
                             (r_nlast[bus.rel_uid] <= CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
            for (int u = 0; u < int'(NUM_UID); u++) r_nlast[u] <= '0;
        end else begin
            if (w_err_limit || w_err_last) r_err <= 1'b1;
            if (w_store_is_last && !(w_rel_is_last && w_same_uid))
                r_nlast[bus.store_id] <= r_nlast[bus.store_id] + CNT_W'(1);
            if (w_rel_is_last && !(w_store_is_last && w_same_uid))
                r_nlast[bus.rel_uid] <= r_nlast[bus.rel_uid] - CNT_W'(1);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_r_resp_memory.sv
// Scoreboard bench for r_resp_memory: per-uid expected queues checked by a negedge monitor.
module tb_r_resp_memory;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] occupancy;
    logic       err;

    int errors   = 0;
    int n_checks = 0;

    logic [66:0] exp_q [16][$];

    r_resp_memory_if bus ();

    r_resp_memory dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int model_occ();
        int s = 0;
        for (int u = 0; u < 16; u++) s += exp_q[u].size();
        return s;
    endfunction

    // Monitor: rel_valid/occupancy against the model, then pop and compare on each release handshake.
    always @(negedge clk) begin
        logic [66:0] e;
        chk("rel_valid", 67'(bus.rel_valid), 67'(exp_q[bus.rel_uid].size() != 0));
        chk("occupancy", 67'(occupancy), 67'(model_occ()));
        if (bus.rel_valid && bus.rel_ready && exp_q[bus.rel_uid].size() != 0) begin
            e = exp_q[bus.rel_uid].pop_front();
            chk("rel_beat", {bus.rel_last, bus.rel_resp, bus.rel_data}, e);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the store is accepted.
    task automatic store(input logic [3:0] id, input logic [63:0] d, input logic [1:0] r, input logic l);
        bus.store_id    = id;
        bus.store_data  = d;
        bus.store_resp  = r;
        bus.store_last  = l;
        bus.store_valid = 1'b1;
        @(negedge clk);
        chk("store_ready", 67'(bus.store_ready), 67'(1));
        @(posedge clk);
        #1;
        bus.store_valid = 1'b0;
        exp_q[id].push_back({l, r, d});
    endtask

    task automatic drain();
        bus.rel_ready = 1'b1;
        for (int u = 0; u < 16; u++) begin
            if (exp_q[u].size() != 0) begin
                int budget = 20;
                bus.rel_uid = 4'(u);
                while (exp_q[u].size() != 0 && budget > 0) begin
                    @(posedge clk);
                    #1;
                    budget--;
                end
                if (exp_q[u].size() != 0) begin
                    n_checks++;
                    errors++;
                    $display("FAIL drain uid %0d: %0d beats left, expected 0", u, exp_q[u].size());
                    exp_q[u].delete();
                end
            end
        end
        bus.rel_ready = 1'b0;
    endtask

    initial begin
        bus.store_valid = 1'b0;
        bus.store_id    = '0;
        bus.store_data  = '0;
        bus.store_resp  = '0;
        bus.store_last  = 1'b0;
        bus.rel_uid     = '0;
        bus.rel_ready   = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_store_ready", 67'(bus.store_ready), 67'(1));
        chk("reset_err", 67'(err), 67'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single uid, three beats, last on the third
        store(4'h5, 64'hD0, 2'd0, 1'b0);
        store(4'h5, 64'hD1, 2'd1, 1'b0);
        store(4'h5, 64'hD2, 2'd2, 1'b1);
        @(negedge clk);
        chk("t1_occ3", 67'(occupancy), 67'(3));
        @(posedge clk); #1;
        drain();
        @(negedge clk);
        chk("t1_occ0", 67'(occupancy), 67'(0));
        @(posedge clk); #1;

        // 2: interleaved uids, release uid7 first then uid3
        store(4'h3, 64'hA0, 2'd0, 1'b0);
        store(4'h7, 64'hB0, 2'd1, 1'b0);
        store(4'h3, 64'hA1, 2'd2, 1'b1);
        store(4'h7, 64'hB1, 2'd3, 1'b1);
        bus.rel_ready = 1'b1;
        bus.rel_uid   = 4'h7;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t2_uid7_empty", 67'(bus.rel_valid), 67'(0));
        @(posedge clk); #1;
        bus.rel_uid = 4'h3;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t2_uid3_empty", 67'(bus.rel_valid), 67'(0));
        @(posedge clk); #1;
        bus.rel_ready = 1'b0;

        // 3: fill the pool, free one slot, confirm it is reused
        for (int i = 0; i < 8; i++) store(4'h1, 64'h100 + 64'(i), 2'd0, 1'(i == 7));
        for (int i = 0; i < 8; i++) store(4'h6, 64'h600 + 64'(i), 2'd1, 1'(i == 7));
        bus.store_id = 4'h9;
        @(negedge clk);
        chk("t3_full_ready", 67'(bus.store_ready), 67'(0));
        chk("t3_full_occ", 67'(occupancy), 67'(16));
        @(posedge clk); #1;
        bus.rel_uid   = 4'h6;
        bus.rel_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_during_rel", 67'(bus.store_ready), 67'(0));
        @(posedge clk); #1;
        bus.rel_ready = 1'b0;
        @(negedge clk);
        chk("t3_ready_after_rel", 67'(bus.store_ready), 67'(1));
        chk("t3_alloc_slot", 67'(dut.w_alloc_slot), 67'(8));
        @(posedge clk); #1;
        store(4'h9, 64'h900, 2'd2, 1'b1);
        @(negedge clk);
        chk("t3_refull_occ", 67'(occupancy), 67'(16));
        chk("t3_err_clear", 67'(err), 67'(0));
        @(posedge clk); #1;
        drain();

        // 4: per-uid limit
        for (int i = 0; i < 8; i++) store(4'h2, 64'h200 + 64'(i), 2'd0, 1'(i == 7));
        bus.store_id = 4'h2;
        @(negedge clk);
        chk("t4_ready_uid2", 67'(bus.store_ready), 67'(0));
        @(posedge clk); #1;
        bus.store_id = 4'h4;
        @(negedge clk);
        chk("t4_ready_uid4", 67'(bus.store_ready), 67'(1));
        @(posedge clk); #1;
        bus.store_id    = 4'h2;
        bus.store_data  = 64'hBAD;
        bus.store_valid = 1'b1;
        @(posedge clk); #1;
        bus.store_valid = 1'b0;
        @(negedge clk);
`ifdef R_RESP_MEM_ERR_EN
        chk("t4_err", 67'(err), 67'(1));
`else
        chk("t4_err", 67'(err), 67'(0));
`endif
        chk("t4_occ", 67'(occupancy), 67'(8));
        @(posedge clk); #1;
        drain();

        // 5: same-cycle release and store on a single-beat uid
        store(4'h9, 64'hC0FFEE, 2'd1, 1'b1);
        bus.rel_uid   = 4'h9;
        bus.rel_ready = 1'b1;
        store(4'h9, 64'hFEED, 2'd3, 1'b1);
        bus.rel_ready = 1'b0;
        @(negedge clk);
        chk("t5_valid", 67'(bus.rel_valid), 67'(1));
        chk("t5_data", 67'(bus.rel_data), 67'(64'hFEED));
        chk("t5_occ", 67'(occupancy), 67'(1));
        @(posedge clk); #1;
        drain();

        // 6: reset mid-traffic discards everything immediately
        store(4'hA, 64'hA00, 2'd0, 1'b0);
        store(4'hA, 64'hA01, 2'd0, 1'b0);
        store(4'hA, 64'hA02, 2'd0, 1'b0);
        store(4'hB, 64'hB00, 2'd0, 1'b0);
        store(4'hB, 64'hB01, 2'd0, 1'b0);
        @(negedge clk);
        chk("t6_occ5", 67'(occupancy), 67'(5));
        @(posedge clk); #1;
        bus.rel_uid     = 4'hA;
        bus.store_id    = 4'hB;
        bus.store_valid = 1'b1;
        #2;
        rst = 1'b1;
        for (int u = 0; u < 16; u++) exp_q[u].delete();
        #1;
        chk("t6_occ0", 67'(occupancy), 67'(0));
        chk("t6_rel_valid", 67'(bus.rel_valid), 67'(0));
        chk("t6_store_ready", 67'(bus.store_ready), 67'(1));
        chk("t6_err", 67'(err), 67'(0));
        bus.store_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        store(4'hB, 64'h5EED, 2'd2, 1'b1);
        drain();
        @(negedge clk);
        chk("t6_final_occ", 67'(occupancy), 67'(0));
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end
endmodule
